// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment hex display driver with a per-frame coherent channel snapshot
// and an integrated step-button debouncer producing a single-cycle step pulse.

module seg_hex_digit (
    input  logic [3:0] nib,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);
    always_comb begin
        seg = 8'hFF;
        seg[7] = ~dp;
        // {g,f,e,d,c,b,a}, active-low
        unique case (nib)
            4'h0: seg[6:0] = 7'h40;
            4'h1: seg[6:0] = 7'h79;
            4'h2: seg[6:0] = 7'h24;
            4'h3: seg[6:0] = 7'h30;
            4'h4: seg[6:0] = 7'h19;
            4'h5: seg[6:0] = 7'h12;
            4'h6: seg[6:0] = 7'h02;
            4'h7: seg[6:0] = 7'h78;
            4'h8: seg[6:0] = 7'h00;
            4'h9: seg[6:0] = 7'h10;
            4'hA: seg[6:0] = 7'h08;
            4'hB: seg[6:0] = 7'h03;
            4'hC: seg[6:0] = 7'h46;
            4'hD: seg[6:0] = 7'h21;
            4'hE: seg[6:0] = 7'h06;
            4'hF: seg[6:0] = 7'h0E;
            default: seg[6:0] = 7'h7F;
        endcase
        if (blank)
            seg[6:0] = 7'h7F;
    end
endmodule

module seg_btn_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic BtnRaw,
    output logic StepPulse
);
    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

    logic          sync_1, sync_2, accepted;
    logic [DW-1:0] stable_cnt;

    // Counting only while the synchronised level differs from the accepted one is
    // equivalent to restarting on every change, since a change back ends the attempt.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            accepted   <= 1'b0;
            stable_cnt <= '0;
            StepPulse  <= 1'b0;
        end else begin
            sync_1    <= BtnRaw;
            sync_2    <= sync_1;
            StepPulse <= 1'b0;
            if (sync_2 == accepted) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DW'(DEB_CYC - 1)) begin
                accepted   <= sync_2;
                stable_cnt <= '0;
                StepPulse  <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end
endmodule

module seg_scan_display #(
    parameter int NDIG     = 4,
    parameter int NCH      = 4,
    parameter int SELW     = 2,
    parameter int REFRESH  = 100000,
    parameter int DEB_CYC  = 1000000,
    parameter int BLANK_LZ = 0
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [SELW-1:0]     Sel,
    input  logic [NCH*32-1:0]   ChData,
    input  logic [NDIG-1:0]     DpMask,
    input  logic                BtnRaw,
    output logic                StepPulse,
    output logic [NDIG-1:0]     AN,
    output logic [7:0]          Seg
);
    localparam int SW = 4 * NDIG;
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [RW-1:0]          ref_cnt;
    logic [IW-1:0]          scan_idx;
    logic [SW-1:0]          snap, chan_sel, disp_src;
    logic                   first_cyc;
    logic                   ref_end, idx_last;
    logic [NDIG-1:0]        blank;
    logic [NDIG-1:0][7:0]   dig_seg;
    logic                   unused_chdata;

    assign unused_chdata = ^ChData;

    always_comb begin
        chan_sel = '0;
        for (int c = 0; c < NCH; c++)
            if (32'(Sel) == c)
                chan_sel = ChData[32*c +: SW];
    end

    assign ref_end  = (ref_cnt == RW'(REFRESH - 1));
    assign idx_last = (scan_idx == IW'(NDIG - 1));

    // On the very first cycle the snapshot is being loaded on the same edge as digit 0
    // lights, so decode from the incoming value rather than the stale register.
    assign disp_src = first_cyc ? chan_sel : snap;

    genvar i;
    generate
        for (i = 0; i < NDIG; i++) begin : g_dig
            if (i == 0) begin : g_first
                assign blank[i] = 1'b0;
            end else begin : g_rest
                assign blank[i] = (BLANK_LZ != 0) && (disp_src[SW-1:4*i] == '0);
            end
            seg_hex_digit u_dig (
                .nib   (disp_src[4*i +: 4]),
                .blank (blank[i]),
                .dp    (DpMask[i]),
                .seg   (dig_seg[i])
            );
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ref_cnt   <= '0;
            scan_idx  <= '0;
            snap      <= '0;
            first_cyc <= 1'b1;
            AN        <= '1;
            Seg       <= 8'hFF;
        end else begin
            first_cyc <= 1'b0;
            AN        <= ~(NDIG'(1) << scan_idx);
            Seg       <= dig_seg[scan_idx];
            if (first_cyc || (ref_end && idx_last))
                snap <= chan_sel;
            if (ref_end) begin
                ref_cnt  <= '0;
                scan_idx <= idx_last ? '0 : scan_idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

    seg_btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .CLK       (CLK),
        .Reset     (Reset),
        .BtnRaw    (BtnRaw),
        .StepPulse (StepPulse)
    );
endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: a plain build and a leading-zero-blanking build
// with three channels share clock, reset, select, dp mask and button.

module tb_seg_scan_display;
    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic [1:0]   Sel = 2'd1;
    logic [127:0] ChData;
    logic [95:0]  ChData_b;
    logic [3:0]   DpMask = 4'h0;
    logic         BtnRaw = 1'b0;

    logic         step_a, step_b;
    logic [3:0]   an_a, an_b;
    logic [7:0]   seg_a, seg_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 CLK = ~CLK;

    seg_scan_display #(.NDIG(4), .NCH(4), .SELW(2), .REFRESH(4), .DEB_CYC(8), .BLANK_LZ(0)) dut (
        .CLK(CLK), .Reset(Reset), .Sel(Sel), .ChData(ChData), .DpMask(DpMask),
        .BtnRaw(BtnRaw), .StepPulse(step_a), .AN(an_a), .Seg(seg_a));

    seg_scan_display #(.NDIG(4), .NCH(3), .SELW(2), .REFRESH(4), .DEB_CYC(8), .BLANK_LZ(1)) dut_b (
        .CLK(CLK), .Reset(Reset), .Sel(Sel), .ChData(ChData_b), .DpMask(DpMask),
        .BtnRaw(BtnRaw), .StepPulse(step_b), .AN(an_b), .Seg(seg_b));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({an_a, seg_a, step_a} !== {4'hF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL reset_a: got an=%h seg=%h step=%b, exp an=F seg=FF step=0", an_a, seg_a, step_a);
            end
            checks++;
            if ({an_b, seg_b, step_b} !== {4'hF, 8'hFF, 1'b0}) begin
                errors++;
                $display("FAIL reset_b: got an=%h seg=%h step=%b, exp an=F seg=FF step=0", an_b, seg_b, step_b);
            end
        end
    endtask

    task automatic test_scan;
        logic [7:0] exp_seg [4] = '{8'hB0, 8'hC6, 8'h92, 8'h88};
        logic [3:0] one_hot;
        int d;
        Reset = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            d = (c - 1) / 4;
            one_hot = 4'b0001 << d;
            checks++;
            if ({an_a, seg_a} !== {~one_hot, exp_seg[d]}) begin
                errors++;
                $display("FAIL scan c=%0d: got an=%h seg=%h, exp an=%h seg=%h", c, an_a, seg_a, ~one_hot, exp_seg[d]);
            end
        end
    endtask

    task automatic test_coherence;
        logic [15:0] v;
        logic [3:0]  one_hot;
        logic [7:0]  es;
        int d;
        for (int c = 17; c <= 48; c++) begin
            tick();
            d = ((c - 1) / 4) % 4;
            v = (c <= 32) ? 16'hA5C3 : 16'h1234;
            one_hot = 4'b0001 << d;
            es = hex_tab[v[4*d +: 4]];
            checks++;
            if ({an_a, seg_a} !== {~one_hot, es}) begin
                errors++;
                $display("FAIL coherence c=%0d: got an=%h seg=%h, exp an=%h seg=%h", c, an_a, seg_a, ~one_hot, es);
            end
            if (c == 22) Sel = 2'd2;
        end
    endtask

    task automatic test_blanking;
        logic [7:0] seg_30 [4] = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
        logic [7:0] seg_00 [4] = '{8'hC0, 8'hFF, 8'h7F, 8'hFF};
        logic [3:0] one_hot;
        logic [7:0] es;
        int d;
        for (int c = 49; c <= 96; c++) begin
            tick();
            d = ((c - 1) / 4) % 4;
            one_hot = 4'b0001 << d;
            es = (c <= 80) ? seg_30[d] : seg_00[d];
            checks++;
            if ({an_b, seg_b} !== {~one_hot, es}) begin
                errors++;
                $display("FAIL blanking c=%0d: got an=%h seg=%h, exp an=%h seg=%h", c, an_b, seg_b, ~one_hot, es);
            end
            if (c == 64) Sel = 2'd3;
            if (c == 80) DpMask = 4'b0100;
        end
        DpMask = 4'h0;
    endtask

    task automatic test_debounce;
        int pulses = 0;
        int pos = 0;
        for (int k = 0; k < 30; k++) begin
            BtnRaw = ((k / 3) % 2) == 0;
            tick();
            if (step_a) pulses++;
        end
        BtnRaw = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (step_a) begin
                pulses++;
                pos = t;
            end
        end
        checks++;
        if (pulses != 1 || pos != 10) begin
            errors++;
            $display("FAIL debounce_press: got %0d pulses at cycle %0d, exp 1 pulse at cycle 10", pulses, pos);
        end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            BtnRaw = ((k / 3) % 2) != 0;
            tick();
            if (step_a) pulses++;
        end
        BtnRaw = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (step_a) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL debounce_release: got %0d pulses, exp 0", pulses);
        end
    endtask

    task automatic test_reset_midop;
        int pulses = 0;
        int pos = 0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (step_a) pulses++;
            if (c == 4) BtnRaw = 1'b1;
        end
        checks++;
        if (an_a !== 4'hB) begin
            errors++;
            $display("FAIL midop_digit2: got an=%h, exp B", an_a);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if ({an_a, seg_a, step_a} !== {4'hF, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL midop_reset: got an=%h seg=%h step=%b, exp an=F seg=FF step=0", an_a, seg_a, step_a);
        end
        Reset = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (step_a) begin
                pulses++;
                pos = t;
            end
            if (t == 1) begin
                checks++;
                if ({an_a, seg_a} !== {4'hE, 8'h90}) begin
                    errors++;
                    $display("FAIL midop_restart: got an=%h seg=%h, exp an=E seg=90", an_a, seg_a);
                end
            end
            if (t == 5) begin
                checks++;
                if (an_a !== 4'hD) begin
                    errors++;
                    $display("FAIL midop_digit1: got an=%h, exp D", an_a);
                end
            end
        end
        checks++;
        if (pulses != 1 || pos != 10) begin
            errors++;
            $display("FAIL midop_held: got %0d pulses, last at cycle %0d, exp 1 pulse at cycle 10", pulses, pos);
        end
        BtnRaw = 1'b0;
    endtask

    initial begin
        ChData   = {32'h0000_00E9, 32'h0000_1234, 32'h0000_A5C3, 32'h0000_0F0F};
        ChData_b = {32'h0000_0030, 32'h0000_7777, 32'h0000_1111};
        test_reset();
        test_scan();
        test_coherence();
        test_blanking();
        test_debounce();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
